axi4lite_regbank_nxm: RTL



---
 rtl/axi4lite_regbank_nxm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/axi4lite_regbank_nxm.sv
// AXI4-Lite slave register bank: N_WR software-written control words followed by N_RD firmware status words.
// Define PIX28_AXI_SLVERR_EN to return SLVERR for unmapped accesses and writes to status words.
module axi4lite_regbank_nxm #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 11,
    parameter int N_WR               = 4,
    parameter int N_RD               = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*N_WR-1:0]              sw_write32,
    output logic [N_WR-1:0]                 sw_write_pulse,
    input  logic [32*N_RD-1:0]              sw_read32,
    output logic [N_RD-1:0]                 sw_read_pulse
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ACK  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]  w_state_q, w_state_d;
    logic [1:0]  r_state_q, r_state_d;
    logic [31:0] regs_q [N_WR];
    logic [31:0] regs_d [N_WR];
    logic [N_WR-1:0] wpulse_q, wpulse_d;
    logic [N_RD-1:0] rpulse_q, rpulse_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] aw_word;
    logic [31:0] ar_word;

    assign aw_word = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign ar_word = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef PIX28_AXI_SLVERR_EN
    logic aw_is_ctrl;
    logic ar_is_mapped;
    assign aw_is_ctrl   = (aw_word < 32'(N_WR));
    assign ar_is_mapped = (ar_word < 32'(N_WR + N_RD));
`endif

    // AW and W are consumed together; address and data are still held by the master in W_ACK.
    always_comb begin
        w_state_d = w_state_q;
        regs_d    = regs_q;
        wpulse_d  = '0;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = W_ACK;
            W_ACK: begin
                w_state_d = W_RESP;
                for (int unsigned k = 0; k < N_WR; k++) begin
                    if (aw_word == 32'(k)) begin
                        wpulse_d[k] = 1'b1;
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (S_AXI_WSTRB[b]) regs_d[k][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                        end
                    end
                end
`ifdef PIX28_AXI_SLVERR_EN
                bresp_d = aw_is_ctrl ? RESP_OKAY : RESP_SLVERR;
`else
                bresp_d = RESP_OKAY;
`endif
            end
            W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // regs_q is sampled before this edge's write lands, so a colliding read returns the old value.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rpulse_d  = '0;
        case (r_state_q)
            R_IDLE: if (S_AXI_ARVALID) r_state_d = R_ACK;
            R_ACK: begin
                r_state_d = R_DATA;
                rdata_d   = '0;
                for (int unsigned k = 0; k < N_WR; k++) begin
                    if (ar_word == 32'(k)) rdata_d = regs_q[k];
                end
                for (int unsigned j = 0; j < N_RD; j++) begin
                    if (ar_word == 32'(N_WR + j)) begin
                        rdata_d     = sw_read32[32*j +: 32];
                        rpulse_d[j] = 1'b1;
                    end
                end
`ifdef PIX28_AXI_SLVERR_EN
                rresp_d = ar_is_mapped ? RESP_OKAY : RESP_SLVERR;
`else
                rresp_d = RESP_OKAY;
`endif
            end
            R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            regs_q    <= '{default: '0};
            wpulse_q  <= '0;
            rpulse_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            regs_q    <= regs_d;
            wpulse_q  <= wpulse_d;
            rpulse_q  <= rpulse_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY  = (w_state_q == W_ACK);
    assign S_AXI_WREADY   = (w_state_q == W_ACK);
    assign S_AXI_BVALID   = (w_state_q == W_RESP);
    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_ARREADY  = (r_state_q == R_ACK);
    assign S_AXI_RVALID   = (r_state_q == R_DATA);
    assign S_AXI_RRESP    = rresp_q;
    assign S_AXI_RDATA    = rdata_q;
    assign sw_write_pulse = wpulse_q;
    assign sw_read_pulse  = rpulse_q;

    always_comb begin
        sw_write32 = '0;
        for (int unsigned k = 0; k < N_WR; k++) sw_write32[32*k +: 32] = regs_q[k];
    end

endmodule
